// File: rtl/amba_mem_master.sv
// rtl/amba_mem_master.sv - single-transfer AHB-lite bus master for the multicycle control unit
// Optional wait-state timeout is built when AMBA_TIMEOUT_EN is defined.
module amba_mem_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} stateT;

   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransNonseq = 2'b10;

   stateT             state, nextState;
   logic [DATA_W-1:0] wdataLatch;
   logic              accept;
   logic              finish;
   logic              timedOut;

   assign HSIZE = 3'b010;

`ifdef AMBA_TIMEOUT_EN
   logic [7:0] waitCnt;

   // Counts consecutive stalled cycles; cleared by any ready cycle or by the abort itself.
   always_ff @(posedge clk) begin
      if (reset)
         waitCnt <= 8'd0;
      else if ((state != IDLE) && !HREADY && !timedOut)
         waitCnt <= waitCnt + 8'd1;
      else
         waitCnt <= 8'd0;
   end

   assign timedOut = (state != IDLE) && (waitCnt == 8'(TIMEOUT));
`else
   assign timedOut = 1'b0;
   if (TIMEOUT > 0) begin : genNoTimeout
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (MemRead || MemWrite) begin
               accept    = 1'b1;
               nextState = ADDR;
            end
         end
         ADDR: begin
            if (timedOut)
               nextState = IDLE;
            else if (HREADY)
               nextState = DATA;
         end
         DATA: begin
            if (timedOut) begin
               nextState = IDLE;
            end else if (HREADY) begin
               finish    = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Bus and status outputs are all registered from the next-state decision.
   always_ff @(posedge clk) begin
      if (reset) begin
         HADDR      <= '0;
         HTRANS     <= TransIdle;
         HWRITE     <= 1'b0;
         HWDATA     <= '0;
         wdataLatch <= '0;
         rdata      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done   <= finish || timedOut;
         busy   <= (nextState != IDLE);
         HTRANS <= (nextState == ADDR) ? TransNonseq : TransIdle;
         if (accept) begin
            HADDR      <= addr;
            HWRITE     <= MemWrite && !MemRead;
            wdataLatch <= wdata;
            err        <= 1'b0;
         end
         if ((state == ADDR) && (nextState == DATA) && HWRITE)
            HWDATA <= wdataLatch;
         if (finish) begin
            if (HRESP)
               err <= 1'b1;
            else if (!HWRITE)
               rdata <= HRDATA;
         end
         if (timedOut)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_amba_mem_master.sv
// tb/tb_amba_mem_master.sv - scoreboard bench for amba_mem_master
// Timeout scenario runs only when AMBA_TIMEOUT_EN is defined.
module tb_amba_mem_master;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              MemRead, MemWrite;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              busy, done, err;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [DATA_W-1:0] HWDATA;
   logic [DATA_W-1:0] HRDATA;
   logic              HREADY, HRESP;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } expT;

   expT               expQ[$];
   logic [DATA_W-1:0] modelRdata;
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   amba_mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
      .err(err), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
      .HRESP(HRESP)
   );

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin : sbMonitor
      expT e;
      if (!reset && done) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done: done=1 with no transfer outstanding");
         end else begin
            e = expQ.pop_front();
            if ({rdata, err} !== {e.rdata, e.err}) begin
               errors++;
               $display("FAIL sb_result: rdata=%h err=%b expected rdata=%h err=%b",
                        rdata, err, e.rdata, e.err);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic isWrite, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] slaveData, input logic slaveErr);
      expT e;
      MemRead  = !isWrite;
      MemWrite = isWrite;
      addr     = a;
      wdata    = d;
      HRDATA   = slaveData;
      HRESP    = slaveErr;
      if (isWrite || slaveErr) begin
         e.rdata = modelRdata;
      end else begin
         e.rdata    = slaveData;
         modelRdata = slaveData;
      end
      e.err = slaveErr;
      expQ.push_back(e);
   endtask

   task automatic test_reset;
      reset = 1'b1; MemRead = 0; MemWrite = 0; addr = '0; wdata = '0;
      HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0; modelRdata = '0;
      tick(); tick();
      checks++;
      if ({HTRANS, HADDR, HWRITE, HWDATA, rdata, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: HTRANS=%b HADDR=%h HWRITE=%b HWDATA=%h rdata=%h busy=%b done=%b err=%b expected all 0",
                  HTRANS, HADDR, HWRITE, HWDATA, rdata, busy, done, err);
      end
      checks++;
      if (HSIZE !== 3'b010) begin
         errors++;
         $display("FAIL reset_hsize: got %b expected 010", HSIZE);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_read;
      issue(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
      tick();
      MemRead = 1'b0;
      checks++;
      if ({HTRANS, HADDR, HWRITE, busy} !== {2'b10, 32'h10, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL read_addr_phase: HTRANS=%b HADDR=%h HWRITE=%b busy=%b expected 10 00000010 0 1",
                  HTRANS, HADDR, HWRITE, busy);
      end
      tick();
      checks++;
      if ({HTRANS, busy, done} !== {2'b00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL read_data_phase: HTRANS=%b busy=%b done=%b expected 00 1 0", HTRANS, busy, done);
      end
      tick();
      checks++;
      if ({done, busy, rdata, err} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
         errors++;
         $display("FAIL read_complete: done=%b busy=%b rdata=%h err=%b expected 1 0 deadbeef 0",
                  done, busy, rdata, err);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL read_done_single: done=%b expected 0", done);
      end
   endtask

   task automatic test_write;
      issue(1'b1, 32'h40, 32'h1234_5678, 32'hA5A5_A5A5, 1'b0);
      tick();
      MemWrite = 1'b0;
      checks++;
      if ({HTRANS, HADDR, HWRITE} !== {2'b10, 32'h40, 1'b1}) begin
         errors++;
         $display("FAIL write_addr_phase: HTRANS=%b HADDR=%h HWRITE=%b expected 10 00000040 1",
                  HTRANS, HADDR, HWRITE);
      end
      tick();
      checks++;
      if ({HTRANS, HWDATA} !== {2'b00, 32'h1234_5678}) begin
         errors++;
         $display("FAIL write_data_phase: HTRANS=%b HWDATA=%h expected 00 12345678", HTRANS, HWDATA);
      end
      tick();
      checks++;
      if ({done, rdata} !== {1'b1, modelRdata}) begin
         errors++;
         $display("FAIL write_complete: done=%b rdata=%h expected 1 %h", done, rdata, modelRdata);
      end
      tick();
   endtask

   task automatic test_wait_states;
      logic readySched[1:5];
      readySched = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      issue(1'b0, 32'h80, 32'h0, 32'h0BAD_F00D, 1'b0);
      HREADY = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         MemRead = 1'b0;
         checks++;
         if ({busy, done, HADDR, HTRANS} !==
             {(c <= 5), (c == 6), 32'h80, (c <= 3) ? 2'b10 : 2'b00}) begin
            errors++;
            $display("FAIL wait_cycle%0d: busy=%b done=%b HADDR=%h HTRANS=%b expected %b %b 00000080 %b",
                     c, busy, done, HADDR, HTRANS, (c <= 5), (c == 6), (c <= 3) ? 2'b10 : 2'b00);
         end
         if (c <= 5) HREADY = readySched[c];
      end
      HREADY = 1'b1;
      tick();
   endtask

   task automatic test_hresp;
      issue(1'b0, 32'h20, 32'h0, 32'h5555_5555, 1'b1);
      tick(); MemRead = 1'b0;
      tick(); tick();
      checks++;
      if ({done, err, rdata} !== {1'b1, 1'b1, modelRdata}) begin
         errors++;
         $display("FAIL hresp_complete: done=%b err=%b rdata=%h expected 1 1 %h", done, err, rdata, modelRdata);
      end
      HRESP = 1'b0;
      tick();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL hresp_err_held: err=%b expected 1", err);
      end
      issue(1'b1, 32'h44, 32'hCAFE_0001, 32'h0, 1'b0);
      tick(); MemWrite = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL hresp_err_cleared: err=%b expected 0", err);
      end
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid;
      issue(1'b0, 32'h30, 32'h0, 32'h7777_7777, 1'b0);
      tick(); MemRead = 1'b0;
      tick();
      reset = 1'b1;
      void'(expQ.pop_back());
      modelRdata = '0;
      tick();
      checks++;
      if ({HTRANS, HADDR, HWRITE, HWDATA, rdata, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: HTRANS=%b HADDR=%h HWRITE=%b HWDATA=%h rdata=%h busy=%b done=%b err=%b expected all 0",
                  HTRANS, HADDR, HWRITE, HWDATA, rdata, busy, done, err);
      end
      reset = 1'b0;
      tick();
      issue(1'b0, 32'h50, 32'h0, 32'h1357_9BDF, 1'b0);
      tick();
      addr = 32'h60;
      tick();
      MemRead = 1'b0;
      checks++;
      if ({HADDR, HTRANS} !== {32'h50, 2'b00}) begin
         errors++;
         $display("FAIL ignore_busy_strobe: HADDR=%h HTRANS=%b expected 00000050 00", HADDR, HTRANS);
      end
      tick();
      checks++;
      if ({done, rdata} !== {1'b1, 32'h1357_9BDF}) begin
         errors++;
         $display("FAIL midreset_next_read: done=%b rdata=%h expected 1 13579bdf", done, rdata);
      end
      tick();
      checks++;
      if ({busy, HTRANS} !== {1'b0, 2'b00}) begin
         errors++;
         $display("FAIL ignore_busy_no_extra: busy=%b HTRANS=%b expected 0 00", busy, HTRANS);
      end
   endtask

   task automatic test_back_to_back;
      issue(1'b0, 32'h88, 32'h0, 32'h2468_ACE0, 1'b0);
      tick(); MemRead = 1'b0;
      tick(); tick();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first_done: done=%b expected 1", done);
      end
      issue(1'b0, 32'h90, 32'h0, 32'h1111_2222, 1'b0);
      tick(); MemRead = 1'b0;
      checks++;
      if ({HTRANS, HADDR, done, busy} !== {2'b10, 32'h90, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL b2b_accept_on_done: HTRANS=%b HADDR=%h done=%b busy=%b expected 10 00000090 0 1",
                  HTRANS, HADDR, done, busy);
      end
      tick(); tick(); tick();
   endtask

`ifdef AMBA_TIMEOUT_EN
   task automatic test_timeout;
      expT e;
      int  doneCycle;
      doneCycle = 0;
      HREADY = 1'b0;
      MemRead = 1'b1; addr = 32'hA0;
      e.rdata = modelRdata;
      e.err   = 1'b1;
      expQ.push_back(e);
      for (int c = 1; c <= 20; c++) begin
         tick();
         MemRead = 1'b0;
         if (done && doneCycle == 0) begin
            doneCycle = c;
            break;
         end
      end
      checks++;
      if ({doneCycle, err, HTRANS, busy} !== {6, 1'b1, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL timeout_abort: done_cycle=%0d err=%b HTRANS=%b busy=%b expected 6 1 00 0",
                  doneCycle, err, HTRANS, busy);
      end
      HREADY = 1'b1;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_read();
      test_write();
      test_wait_states();
      test_hresp();
      test_reset_mid();
      test_back_to_back();
`ifdef AMBA_TIMEOUT_EN
      test_timeout();
`endif
      tick();
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d transfers outstanding expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/amba_mem_master.md
# amba_mem_master

Bus-master bridge between the multicycle control unit and the shared AMBA memory bus. It turns the control unit's one-cycle `MemRead`/`MemWrite` strobes, the muxed address (PC or ALU result, chosen by `IorD`) and the B-register write data into a single AHB-lite style transfer. For reads it holds the returned word in a memory-data register. With zero wait states a transfer completes inside the control unit's 4-cycle bus-lock window.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 15, max consecutive wait cycles (used only with `AMBA_TIMEOUT_EN`); range 1..255

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `MemRead`  in  1  read request strobe from control
- `MemWrite`  in  1  write request strobe from control
- `addr`  in  ADDR_W  transfer address (post-`IorD` mux)
- `wdata`  in  DATA_W  write data
- `rdata`  out  DATA_W  memory-data register: last word read
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  last transfer failed (HRESP or timeout)
- `HADDR`  out  ADDR_W  bus address
- `HTRANS`  out  2  2'b00 IDLE, 2'b10 NONSEQ
- `HWRITE`  out  1  1 = write
- `HSIZE`  out  3  constant 3'b010 (word)
- `HWDATA`  out  DATA_W  bus write data
- `HRDATA`  in  DATA_W  bus read data
- `HREADY`  in  1  slave ready
- `HRESP`  in  1  1 = ERROR

## Operation
- States: IDLE, ADDR, DATA. All outputs are registered.
- IDLE:
  - `MemRead|MemWrite` high at a rising edge → latch `addr` and `wdata`; set `HWRITE = MemWrite & ~MemRead`; go to ADDR.
  - Read wins if both strobes are high.
  - Clear `err` on acceptance.
- ADDR:
  - Drives `HTRANS`=NONSEQ, `HADDR`=latched addr, and `HWRITE`.
  - `HREADY`=1 → DATA. `HREADY`=0 → stay, holding all bus outputs.
- DATA:
  - Drives `HTRANS`=IDLE; `HWDATA`=latched wdata (write) or held at the last value (read).
  - `HREADY`=1 → IDLE, assert `done` for one cycle.
  - On a read, load `rdata` from `HRDATA`.
  - If `HRESP`=1 at that edge: set `err`, leave `rdata` unchanged, still pulse `done`.
  - `HREADY`=0 → stay.
- `busy` = (state != IDLE).
- Strobes arriving while `busy` are ignored, not queued. The control unit guarantees one strobe per lock window.
- `rdata` holds its value until the next successful read or reset.

## Timing
- Reset values: state IDLE, `HTRANS`=00, `HADDR`=0, `HWRITE`=0, `HWDATA`=0, `rdata`=0, `busy`=0, `done`=0, `err`=0, wait counter 0.
- Zero-wait transfer, strobe sampled at edge 0:
  - cycle 1: ADDR phase.
  - cycle 2: DATA phase.
  - edge 3: `rdata` valid, `done` high for cycle 3.
- Request-to-`rdata` latency is 3 cycles, inside the control unit's 4-cycle lock.
- Each HREADY-low cycle adds one cycle.
- A strobe sampled in the same cycle `done` is high is accepted, because the block is already in IDLE.
- Reset mid-transfer aborts immediately:
  - next cycle shows reset values on all outputs;
  - no `done` pulse;
  - the partially read word is discarded.

## Configuration
- `AMBA_TIMEOUT_EN` defined:
  - An 8-bit counter counts consecutive HREADY-low cycles in ADDR or DATA, and resets on any HREADY-high cycle.
  - When the count reaches `TIMEOUT`, the transfer aborts at the next edge: state → IDLE, `HTRANS`=IDLE, `err`=1, `done` pulses, `rdata` unchanged.
- Undefined:
  - No counter is built; the block waits on HREADY indefinitely.
  - `TIMEOUT` is unused.

## Test plan
- Reset, then a `MemRead` pulse with addr=0x0000_0010, HREADY=1, HRDATA=0xDEAD_BEEF → `HTRANS`=10 at cycle 1, `rdata`=0xDEAD_BEEF and `done`=1 at cycle 3, `err`=0.
- `MemWrite` pulse with addr=0x40, wdata=0x1234_5678 → `HWRITE`=1 in ADDR, `HWDATA`=0x1234_5678 in DATA, `done` at cycle 3, `rdata` unchanged.
- Read with HREADY=0 for 2 cycles in ADDR and 1 cycle in DATA → bus outputs held stable, `done` at cycle 6, `busy` high for cycles 1–5.
- Read completing with HRESP=1, HREADY=1 → `err`=1, `done` pulses, `rdata` keeps its prior value; next accepted strobe clears `err`.
- Reset asserted during DATA of a read → next cycle all outputs at reset values, no `done`; a second `MemRead` pulse during `busy` of a new transfer is ignored.
- With `AMBA_TIMEOUT_EN` and `TIMEOUT`=4, HREADY held 0 → abort after 4 wait cycles, `err`=1, `done`=1, `HTRANS`=00.
